gpr_wb_arbiter: RTL and testbench
=================================

// Module: gpr_wb_arbiter
// PURPOSE
//  Shares the single GPR write port (reg_write_en/dest/data) between NREQ writeback requesters
//  (ALU, load unit, ...) using round-robin arbitration with a valid/ready handshake.
//  The winning write is registered into a one-entry write stage that drives the GPR write port.
//  Two read-address bypass lanes forward the in-flight write to readers, since the GPR file
//  reads combinationally and has not yet captured the staged data.
// PARAMETERS
//  NREQ    4   number of writeback requesters (2..8)
//  DATA_W  16  register data width
//  ADDR_W  3   register address width (8 GPRs)
// PORTS
//  clk             in   1             rising-edge clock
//  rst             in   1             synchronous reset, active high
//  arb_en          in   1             1 = arbitration enabled; 0 = no new grants (drain/stall)
//  req_valid       in   NREQ          per-requester write request
//  req_dest        in   NREQ*ADDR_W   packed destinations, requester i at [i*ADDR_W +: ADDR_W]
//  req_data        in   NREQ*DATA_W   packed write data, requester i at [i*DATA_W +: DATA_W]
//  req_ready       out  NREQ          one-hot grant; transfer on req_valid[i] & req_ready[i]
//  reg_write_en    out  1             to GPR write enable (registered)
//  reg_write_dest  out  ADDR_W        to GPR write address (registered)
//  reg_write_data  out  DATA_W        to GPR write data (registered)
//  byp_addr1       in   ADDR_W        read address of GPR read port 1
//  byp_hit1        out  1             staged write targets byp_addr1
//  byp_data1       out  DATA_W        forwarded data for port 1 (= reg_write_data)
//  byp_addr2       in   ADDR_W        read address of GPR read port 2
//  byp_hit2        out  1             staged write targets byp_addr2
//  byp_data2       out  DATA_W        forwarded data for port 2
// BEHAVIOUR
//  Reset (rst=1 at posedge): reg_write_en=0, reg_write_dest=0, reg_write_data=0, rr_ptr=0.
//  Any staged write is dropped, not committed. req_ready is 0 while rst=1.
//  Arbitration (combinational): search req_valid starting at index rr_ptr, wrapping modulo NREQ.
//  The first valid index gets req_ready=1; all others get 0. No grant if arb_en=0 or no valid.
//  req_ready never depends on data/dest; at most one bit is set.
//  Pointer: on a transfer by requester g, rr_ptr <= (g+1) mod NREQ; otherwise rr_ptr holds.
//  Write stage: the GPR port accepts a write every cycle, so the stage never back-pressures.
//  Full throughput is 1 write per cycle.
//  On a transfer: next cycle reg_write_en=1 with the granted dest/data (latency 1 cycle).
//  With no transfer: reg_write_en=0 next cycle; dest/data hold their last values.
//  The GPR file commits the staged write at the posedge ending the cycle in which reg_write_en=1.
//  Bypass (combinational): byp_hitK = reg_write_en & (byp_addrK == reg_write_dest).
//  byp_dataK = reg_write_data always; consumers select it only when byp_hitK=1.
//  Simultaneous requests to the same dest: served in round-robin order, one per cycle.
//  The last-served write wins in the GPR file.
//  Requester holds valid/dest/data stable until granted; a dropped valid before grant is legal.
//  arb_en falling: a write already staged still commits; no new grants until arb_en=1.
//  Address 0 is an ordinary writable register; no special-casing.
// TESTING
//  1. rst=1 for 2 cycles, all req_valid=1 -> req_ready=0, reg_write_en=0, byp_hit*=0.
//  2. Only req1 valid, dest=5, data=16'hBEEF -> req_ready=4'b0010.
//     Next cycle reg_write_en=1, dest=5, data=BEEF, rr_ptr=2.
//  3. All 4 valid held 8 cycles after reset -> grant order 0,1,2,3,0,1,2,3, reg_write_en=1 each cycle.
//  4. Stage holds dest=3, data=16'h1234; byp_addr1=3, byp_addr2=4 -> byp_hit1=1, byp_data1=1234, byp_hit2=0.
//  5. arb_en=0 with req2 valid -> req_ready=0 while low.
//     Raise arb_en -> req2 granted same cycle, written next cycle.
//  6. rst asserted in the cycle after a grant of dest=6, data=16'h00FF -> reg_write_en=0 next cycle.
//     GPR6 is unchanged and rr_ptr returns to 0.

Source files
------------

// File: rtl/gpr_wb_arbiter.sv
// Round-robin arbiter sharing the single GPR write port between NREQ writeback requesters,
// with a one-entry registered write stage and two read-address bypass lanes.
module gpr_wb_arbiter #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arb_en,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*ADDR_W-1:0]   req_dest,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     reg_write_en,
    output logic [ADDR_W-1:0]        reg_write_dest,
    output logic [DATA_W-1:0]        reg_write_data,
    input  logic [ADDR_W-1:0]        byp_addr1,
    output logic                     byp_hit1,
    output logic [DATA_W-1:0]        byp_data1,
    input  logic [ADDR_W-1:0]        byp_addr2,
    output logic                     byp_hit2,
    output logic [DATA_W-1:0]        byp_data2
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  rr_ptr_nxt;
    logic [PTR_W-1:0]  gnt_idx;
    logic              xfer;
    logic [ADDR_W-1:0] sel_dest;
    logic [DATA_W-1:0] sel_data;
    int unsigned       scan;

    // Search from rr_ptr, wrapping; the first valid requester wins. Grant never depends on payload.
    always_comb begin
        req_ready = '0;
        gnt_idx   = '0;
        xfer      = 1'b0;
        scan      = 0;
        for (int i = 0; i < NREQ; i++) begin
            scan = 32'(rr_ptr) + 32'(i);
            if (scan >= NREQ) begin
                scan = scan - NREQ;
            end
            if (!xfer && arb_en && !rst && req_valid[scan]) begin
                xfer            = 1'b1;
                gnt_idx         = PTR_W'(scan);
                req_ready[scan] = 1'b1;
            end
        end
    end

    always_comb begin
        sel_dest   = req_dest[gnt_idx*ADDR_W +: ADDR_W];
        sel_data   = req_data[gnt_idx*DATA_W +: DATA_W];
        rr_ptr_nxt = (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end

    // Write stage: reset drops any staged write; dest/data hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_en   <= 1'b0;
            reg_write_dest <= '0;
            reg_write_data <= '0;
            rr_ptr         <= '0;
        end else begin
            reg_write_en <= xfer;
            if (xfer) begin
                reg_write_dest <= sel_dest;
                reg_write_data <= sel_data;
                rr_ptr         <= rr_ptr_nxt;
            end
        end
    end

    // The GPR file has not captured the staged write yet, so forward it to readers.
    always_comb begin
        byp_hit1  = reg_write_en && (byp_addr1 == reg_write_dest);
        byp_hit2  = reg_write_en && (byp_addr2 == reg_write_dest);
        byp_data1 = reg_write_data;
        byp_data2 = reg_write_data;
    end

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed self-checking bench for gpr_wb_arbiter with a small GPR-file model
// that commits the staged write at the edge ending its cycle.
module tb_gpr_wb_arbiter;

    localparam int unsigned NREQ   = 4;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 3;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   arb_en;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*ADDR_W-1:0] req_dest;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   reg_write_en;
    logic [ADDR_W-1:0]      reg_write_dest;
    logic [DATA_W-1:0]      reg_write_data;
    logic [ADDR_W-1:0]      byp_addr1;
    logic                   byp_hit1;
    logic [DATA_W-1:0]      byp_data1;
    logic [ADDR_W-1:0]      byp_addr2;
    logic                   byp_hit2;
    logic [DATA_W-1:0]      byp_data2;

    logic [DATA_W-1:0]      gpr [8];
    int                     checks = 0;
    int                     failures = 0;

    gpr_wb_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .arb_en(arb_en),
        .req_valid(req_valid), .req_dest(req_dest), .req_data(req_data), .req_ready(req_ready),
        .reg_write_en(reg_write_en), .reg_write_dest(reg_write_dest), .reg_write_data(reg_write_data),
        .byp_addr1(byp_addr1), .byp_hit1(byp_hit1), .byp_data1(byp_data1),
        .byp_addr2(byp_addr2), .byp_hit2(byp_hit2), .byp_data2(byp_data2)
    );

    always #5 clk = ~clk;

    // GPR file: reset-aware, so a write staged while rst is high is not committed.
    always @(posedge clk) begin
        if (reg_write_en && !rst) gpr[reg_write_dest] <= reg_write_data;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [ADDR_W-1:0] d, input logic [DATA_W-1:0] v);
        req_dest[i*ADDR_W +: ADDR_W] = d;
        req_data[i*DATA_W +: DATA_W] = v;
    endtask

    initial begin
        for (int r = 0; r < 8; r++) gpr[r] = '0;
        rst = 1'b1; arb_en = 1'b1; req_valid = 4'b1111;
        req_dest = '0; req_data = '0; byp_addr1 = '0; byp_addr2 = '0;

        // 1: reset with all requesters valid
        step(); step();
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_wen", 32'(reg_write_en), 32'h0);
        check("rst_dest", 32'(reg_write_dest), 32'h0);
        check("rst_data", 32'(reg_write_data), 32'h0);
        check("rst_hit1", 32'(byp_hit1), 32'h0);
        check("rst_hit2", 32'(byp_hit2), 32'h0);

        // 2: single requester 1
        rst = 1'b0; req_valid = 4'b0010; set_req(1, 3'd5, 16'hBEEF);
        #1 check("t2_ready", 32'(req_ready), 32'h2);
        step();
        req_valid = 4'b0111;
        #1;
        check("t2_wen", 32'(reg_write_en), 32'h1);
        check("t2_dest", 32'(reg_write_dest), 32'h5);
        check("t2_data", 32'(reg_write_data), 32'hBEEF);
        check("t2_ptr2", 32'(req_ready), 32'h4);
        req_valid = 4'b0000;
        step();
        check("t2_idle_wen", 32'(reg_write_en), 32'h0);
        check("t2_hold_dest", 32'(reg_write_dest), 32'h5);
        check("t2_hold_data", 32'(reg_write_data), 32'hBEEF);
        check("t2_gpr5", 32'(gpr[5]), 32'hBEEF);

        // 3: all four valid for 8 cycles right after reset
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 3'((i + 5) % 8), 16'(16'hA000 + i));
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1 check($sformatf("t3_ready%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
            step();
            check($sformatf("t3_wen%0d", k), 32'(reg_write_en), 32'h1);
            check($sformatf("t3_dest%0d", k), 32'(reg_write_dest), 32'((k % 4 + 5) % 8));
            check($sformatf("t3_data%0d", k), 32'(reg_write_data), 32'(16'hA000 + k % 4));
        end
        req_valid = 4'b0000;
        step();
        check("t3_gpr0", 32'(gpr[0]), 32'hA003);
        check("t3_gpr6", 32'(gpr[6]), 32'hA001);

        // 4: bypass lanes, pointer is back at 0
        req_valid = 4'b0001; set_req(0, 3'd3, 16'h1234);
        step();
        req_valid = 4'b0000; byp_addr1 = 3'd3; byp_addr2 = 3'd4;
        #1;
        check("t4_hit1", 32'(byp_hit1), 32'h1);
        check("t4_data1", 32'(byp_data1), 32'h1234);
        check("t4_hit2", 32'(byp_hit2), 32'h0);
        check("t4_data2", 32'(byp_data2), 32'h1234);
        step();
        check("t4_hit1_gone", 32'(byp_hit1), 32'h0);
        check("t4_gpr3", 32'(gpr[3]), 32'h1234);

        // 5: arb_en low stalls grants
        arb_en = 1'b0; req_valid = 4'b0100; set_req(2, 3'd2, 16'h5555);
        for (int k = 0; k < 3; k++) begin
            #1 check($sformatf("t5_stall_ready%0d", k), 32'(req_ready), 32'h0);
            step();
            check($sformatf("t5_stall_wen%0d", k), 32'(reg_write_en), 32'h0);
        end
        arb_en = 1'b1;
        #1 check("t5_ready", 32'(req_ready), 32'h4);
        step();
        req_valid = 4'b0000;
        check("t5_wen", 32'(reg_write_en), 32'h1);
        check("t5_dest", 32'(reg_write_dest), 32'h2);
        check("t5_data", 32'(reg_write_data), 32'h5555);

        // 6: reset in the cycle after a grant drops the staged write
        req_valid = 4'b1000; set_req(3, 3'd6, 16'h00FF);
        #1 check("t6_ready", 32'(req_ready), 32'h8);
        step();
        req_valid = 4'b0000; rst = 1'b1;
        #1;
        check("t6_staged_wen", 32'(reg_write_en), 32'h1);
        check("t6_staged_dest", 32'(reg_write_dest), 32'h6);
        check("t6_rst_ready", 32'(req_ready), 32'h0);
        step();
        rst = 1'b0;
        check("t6_wen", 32'(reg_write_en), 32'h0);
        step();
        check("t6_gpr6", 32'(gpr[6]), 32'hA001);
        req_valid = 4'b1111;
        #1 check("t6_ptr0", 32'(req_ready), 32'h1);
        req_valid = 4'b0000;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
